// File: rtl/aes_pkg.sv
// aes_pkg: shared ShiftRows constants, buffer state encoding and index helpers
package aes_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;
  function automatic bit nb_legal(input int nb);
    return nb == 4 || nb == 6 || nb == 8;
  endfunction
  function automatic int shift_offset(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction
  function automatic int byte_idx(input int c, input int r);
    return 4 * c + r;
  endfunction
endpackage

// File: rtl/shift_rows_comb.sv
// shift_rows_comb: combinational Rijndael ShiftRows / InvShiftRows byte permutation
module shift_rows_comb
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:WORD_W*NB-1] data,
  input  logic                 enc,
  output logic [0:WORD_W*NB-1] shifted
);
  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_comb: NB must be 4, 6 or 8");
  end
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S = shift_offset(NB, r);
      assign shifted[8*byte_idx(c, r) +: 8] = enc ? data[8*byte_idx((c + S) % NB, r) +: 8]
                                                  : data[8*byte_idx((c - S + NB) % NB, r) +: 8];
    end
  end
endmodule

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: ShiftRows stage with valid/ready stream and 2-entry output FIFO
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:WORD_W*NB-1] in_data,
  input  logic                 in_enc,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:WORD_W*NB-1] out_data,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int BLK_W = WORD_W * NB;
  buf_state_t         r_state;
  logic               r_wptr;
  logic               r_rptr;
  logic [0:BLK_W-1]   r_data [2];
  logic [TAG_W-1:0]   r_tag  [2];
  logic [0:BLK_W-1]   w_shifted;
  logic               w_push;
  logic               w_pop;
  buf_state_t         w_state_nxt;

  shift_rows_comb #(.NB(NB)) u_comb (
    .data    (in_data),
    .enc     (in_enc),
    .shifted (w_shifted)
  );

  assign in_ready  = r_state != FULL;
  assign out_valid = r_state != EMPTY;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? r_data[r_rptr] : '0;
  assign out_tag   = out_valid ? r_tag[r_rptr] : '0;

  // occupancy follows push/pop; a simultaneous push and pop keeps the level
  always_comb begin
    w_state_nxt = (w_push && !w_pop) ? (r_state == EMPTY ? ONE : FULL) :
                  (!w_push && w_pop) ? (r_state == FULL ? ONE : EMPTY) : r_state;
  end

  // buffer state and pointers; flush empties the FIFO and beats push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end

  // storage is unreset; out_data/out_tag are masked while empty
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_data[r_wptr] <= w_shifted;
      r_tag[r_wptr]  <= in_tag;
    end
  end
endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: scoreboard bench for the ShiftRows stream stage (NB=4 and NB=8)
module tb_shift_rows_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, in_enc = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [0:127] in_data = '0;
  logic [0:127] out_data;
  logic [3:0] in_tag = '0;
  logic [3:0] out_tag;
  logic e_flush = 1'b0, e_in_valid = 1'b0, e_in_enc = 1'b0, e_out_ready = 1'b0;
  logic e_in_ready, e_out_valid;
  logic [0:255] e_in_data = '0;
  logic [0:255] e_out_data;
  logic [3:0] e_in_tag = '0;
  logic [3:0] e_out_tag;
  int total = 0;
  int bad = 0;
  logic [0:127] qd[$];
  logic [3:0] qt[$];
  logic [0:127] sb_d;
  logic [3:0] sb_t;
  logic [0:255] sb_m;
  localparam logic [0:127] V4 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] E4 = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [0:127] D4 = 128'h000d0a0704010e0b0805020f0c090603;

  shift_rows_stream #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_enc(in_enc), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  shift_rows_stream #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_data(e_in_data), .in_enc(e_in_enc), .in_tag(e_in_tag), .out_valid(e_out_valid),
    .out_ready(e_out_ready), .out_data(e_out_data), .out_tag(e_out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [0:255] model(input logic [0:255] d, input int nb, input logic enc);
    logic [0:255] m;
    int s [4];
    int src;
    m = '0;
    s[0] = 0;
    s[1] = 1;
    s[2] = (nb == 8) ? 3 : 2;
    s[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = enc ? (c + s[r]) % nb : (c - s[r] + nb) % nb;
        m[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
      end
    return m;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // scoreboard: pop before push so a same-cycle push never becomes the compared head
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && !flush) begin
        total++;
        if (qd.size() == 0) begin
          bad++;
          $display("FAIL sb_extra got tag=%0d data=%h exp=nothing", out_tag, out_data);
        end else begin
          sb_d = qd.pop_front();
          sb_t = qt.pop_front();
          if (out_data !== sb_d || out_tag !== sb_t) begin
            bad++;
            $display("FAIL sb_out got tag=%0d data=%h exp tag=%0d data=%h", out_tag, out_data, sb_t, sb_d);
          end
        end
      end
      if (in_valid && in_ready && !flush) begin
        sb_m = model({in_data, 128'b0}, 4, in_enc);
        qd.push_back(sb_m[0:127]);
        qt.push_back(in_tag);
      end
    end
  end

  task automatic drive4(input logic [0:127] d, input logic e, input logic [3:0] t);
    in_valid = 1'b1;
    in_data = d;
    in_enc = e;
    in_tag = t;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
    total++; if (e_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid8 got=%b exp=0", e_out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_enc4();
    out_ready = 1'b0;
    drive4(V4, 1'b1, 4'd5);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL enc4_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== E4) begin bad++; $display("FAIL enc4_data got=%h exp=%h", out_data, E4); end
    total++; if (out_tag !== 4'd5) begin bad++; $display("FAIL enc4_tag got=%0d exp=5", out_tag); end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL enc4_drain got=%b exp=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_dec4_roundtrip();
    drive4(V4, 1'b0, 4'd6);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_data !== D4) begin bad++; $display("FAIL dec4_data got=%h exp=%h", out_data, D4); end
    @(posedge clk); #1 out_ready = 1'b1;
    drive4(D4, 1'b1, 4'd7);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rt_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== V4) begin bad++; $display("FAIL rt_data got=%h exp=%h", out_data, V4); end
    total++; if (out_tag !== 4'd7) begin bad++; $display("FAIL rt_tag got=%0d exp=7", out_tag); end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_nb8();
    logic [0:255] v;
    logic [0:255] exp8;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = 8'(k);
    exp8 = model(v, 8, 1'b1);
    e_in_valid = 1'b1; e_in_data = v; e_in_enc = 1'b1; e_in_tag = 4'd9;
    @(posedge clk); #1 e_in_valid = 1'b0;
    @(negedge clk);
    total++; if (e_out_valid !== 1'b1) begin bad++; $display("FAIL nb8_valid got=%b exp=1", e_out_valid); end
    total++; if (e_out_data[24 +: 8] !== 8'h13) begin bad++; $display("FAIL nb8_b03 got=%h exp=13", e_out_data[24 +: 8]); end
    total++; if (e_out_data[16 +: 8] !== 8'h0e) begin bad++; $display("FAIL nb8_b02 got=%h exp=0e", e_out_data[16 +: 8]); end
    total++; if (e_out_data[8 +: 8] !== 8'h05) begin bad++; $display("FAIL nb8_b01 got=%h exp=05", e_out_data[8 +: 8]); end
    total++; if (e_out_data[248 +: 8] !== 8'h0f) begin bad++; $display("FAIL nb8_b73 got=%h exp=0f", e_out_data[248 +: 8]); end
    total++; if (e_out_data !== exp8) begin bad++; $display("FAIL nb8_full got=%h exp=%h", e_out_data, exp8); end
    total++; if (e_out_tag !== 4'd9) begin bad++; $display("FAIL nb8_tag got=%0d exp=9", e_out_tag); end
    @(posedge clk); #1 e_out_ready = 1'b1;
    @(posedge clk); #1 e_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit acc = 0;
    out_ready = 1'b0;
    drive4(rnd128(), 1'b1, 4'd1);
    @(posedge clk); #1 drive4(rnd128(), 1'b0, 4'd2);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    @(posedge clk); #1 drive4(rnd128(), 1'b1, 4'd3);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL bp_accept got=stuck exp=accepted"); end
    for (int i = 0; i < 8 && qd.size() != 0; i++) @(negedge clk);
    total++; if (qd.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d left exp=0", qd.size()); end
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive4(rnd128(), i[0], i[3:0]);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL st_ready%0d got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL st_valid%0d got=%b exp=1", i, out_valid); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL st_last got=%b exp=1", out_valid); end
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++; if (qd.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL st_drain got=%0d/%b exp=0/0", qd.size(), out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive4(rnd128(), 1'b1, 4'd10);
    @(posedge clk); #1 drive4(rnd128(), 1'b0, 4'd11);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_full got=%b exp=0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rm_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
    qd.delete();
    qt.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 drive4(rnd128(), 1'b1, 4'd12);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_tag !== 4'd12) begin bad++; $display("FAIL rm_after got=%b/%0d exp=1/12", out_valid, out_tag); end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive4(rnd128(), 1'b1, 4'd13);
    @(posedge clk); #1 drive4(rnd128(), 1'b1, 4'd14);
    flush = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    qd.delete();
    qt.delete();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1 drive4(rnd128(), 1'b0, 4'd15);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_tag !== 4'd15) begin bad++; $display("FAIL fl_after got=%b/%0d exp=1/15", out_valid, out_tag); end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || qd.size() != 0) begin bad++; $display("FAIL fl_drain got=%b/%0d exp=0/0", out_valid, qd.size()); end
  endtask

  initial begin
    test_reset();
    test_enc4();
    test_dec4_roundtrip();
    test_nb8();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
